// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle for the L1 data cache controller.
// Signal suffixes are from the controller's point of view.
interface dcache_controller_if #(
   parameter int LINE_BITS = 256
);
   logic [31:0]          cpu_addr_i;
   logic [31:0]          cpu_data_i;
   logic                 cpu_MemRead_i;
   logic                 cpu_MemWrite_i;
   logic [31:0]          cpu_data_o;
   logic                 cpu_stall_o;
   logic [31:0]          mem_addr_o;
   logic [LINE_BITS-1:0] mem_data_o;
   logic                 mem_enable_o;
   logic                 mem_write_o;
   logic [LINE_BITS-1:0] mem_data_i;
   logic                 mem_ack_i;

   modport master (
      output cpu_addr_i,
      output cpu_data_i,
      output cpu_MemRead_i,
      output cpu_MemWrite_i,
      input  cpu_data_o,
      input  cpu_stall_o,
      input  mem_addr_o,
      input  mem_data_o,
      input  mem_enable_o,
      input  mem_write_o,
      output mem_data_i,
      output mem_ack_i
   );

   modport slave (
      input  cpu_addr_i,
      input  cpu_data_i,
      input  cpu_MemRead_i,
      input  cpu_MemWrite_i,
      output cpu_data_o,
      output cpu_stall_o,
      output mem_addr_o,
      output mem_data_o,
      output mem_enable_o,
      output mem_write_o,
      input  mem_data_i,
      input  mem_ack_i
   );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Stalls the whole pipeline while a miss is written back and refilled.
module dcache_controller #(
   parameter int LINES     = 16,
   parameter int LINE_BITS = 256,
   parameter int TAG_BITS  = 23
) (
   input logic          clk_i,
   input logic          rst_i,
   dcache_controller_if.slave bus
);
   localparam int IDX_BITS  = $clog2(LINES);
   localparam int WORDS     = LINE_BITS / 32;
   localparam int WSEL_BITS = $clog2(WORDS);
   localparam int OFF_BITS  = WSEL_BITS + 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITEBACK,
      S_REFILL,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [LINES-1:0]     r_valid;
   logic [LINES-1:0]     r_dirty;
   logic [TAG_BITS-1:0]  r_tag  [LINES];
   logic [LINE_BITS-1:0] r_data [LINES];

   logic [IDX_BITS-1:0]  w_idx;
   logic [TAG_BITS-1:0]  w_tag;
   logic [WSEL_BITS-1:0] w_wsel;
   logic [LINE_BITS-1:0] w_line;
   logic [31:0]          w_word;
   logic                 w_req;
   logic                 w_we;
   logic                 w_hit;
   logic                 w_wr_hit;
   logic                 w_fill;
   logic                 w_unused_addr;

   assign w_idx  = bus.cpu_addr_i[OFF_BITS +: IDX_BITS];
   assign w_tag  = bus.cpu_addr_i[31 -: TAG_BITS];
   assign w_wsel = bus.cpu_addr_i[2 +: WSEL_BITS];
   assign w_unused_addr = &{1'b0, bus.cpu_addr_i[1:0]};

   assign w_line = r_data[w_idx];
   assign w_word = w_line[{w_wsel, 5'b0} +: 32];

   // A simultaneous read and write request is a store.
   assign w_req = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
   assign w_we  = bus.cpu_MemWrite_i;
   assign w_hit = r_valid[w_idx] & (r_tag[w_idx] == w_tag);

   assign w_wr_hit = !rst_i & w_req & w_we & w_hit
                     & (r_state == S_IDLE);
   assign w_fill   = (r_state == S_REFILL) & bus.mem_ack_i;

   assign bus.cpu_stall_o = !rst_i & w_req
                            & ((r_state != S_IDLE) | !w_hit);
   assign bus.cpu_data_o  = (!rst_i & w_req & w_hit) ? w_word
                                                     : 32'h0;

   // Memory side is a pure decode of the state register.
   always_comb begin
      bus.mem_enable_o = 1'b0;
      bus.mem_write_o  = 1'b0;
      bus.mem_addr_o   = 32'h0;
      bus.mem_data_o   = '0;
      unique case (r_state)
         S_WRITEBACK: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_write_o  = 1'b1;
            bus.mem_addr_o   = {r_tag[w_idx], w_idx,
                                {OFF_BITS{1'b0}}};
            bus.mem_data_o   = w_line;
         end
         S_REFILL: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_addr_o   = {w_tag, w_idx,
                                {OFF_BITS{1'b0}}};
         end
         S_IDLE, S_DONE: begin
            bus.mem_enable_o = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_valid <= '0;
         r_dirty <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_wr_hit)
                  r_dirty[w_idx] <= 1'b1;
               if (w_req & !w_hit) begin
                  if (r_valid[w_idx] & r_dirty[w_idx])
                     r_state <= S_WRITEBACK;
                  else
                     r_state <= S_REFILL;
               end
            end
            S_WRITEBACK: begin
               if (bus.mem_ack_i)
                  r_state <= S_REFILL;
            end
            S_REFILL: begin
               if (bus.mem_ack_i) begin
                  r_valid[w_idx] <= 1'b1;
                  r_dirty[w_idx] <= 1'b0;
                  r_state        <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Tag and data arrays carry no reset; validity is tracked above.
   always_ff @(posedge clk_i) begin
      if (w_fill) begin
         r_tag[w_idx]  <= w_tag;
         r_data[w_idx] <= bus.mem_data_i;
      end else if (w_wr_hit) begin
         r_data[w_idx][{w_wsel, 5'b0} +: 32] <= bus.cpu_data_i;
      end
   end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: misses, hits, write-back,
// write-allocate, stray acks, dual requests and reset mid-refill.
module tb_dcache_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   int             stalls;
   int             wbn;
   logic [255:0]   wb_line;
   logic [31:0]    wb_addr;
   logic [31:0]    rf_addr;
   bit             done;
   logic [255:0]   line_a;

   dcache_controller_if bus ();

   dcache_controller dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk32(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs,
                       input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] mkline(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++)
         l[i*32 +: 32] = base + 32'(i);
      return l;
   endfunction

   task automatic req(input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] data);
      bus.cpu_MemRead_i  = rd;
      bus.cpu_MemWrite_i = wr;
      bus.cpu_addr_i     = addr;
      bus.cpu_data_i     = data;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Acts as memory for one miss; returns in the first cycle without stall.
   task automatic serve(input int wb_lat, input int rf_lat,
                        input logic [255:0] line,
                        output int n_stall, output int n_wb,
                        output logic [255:0] o_wb_line,
                        output logic [31:0] o_wb_addr,
                        output logic [31:0] o_rf_addr,
                        output bit o_done);
      int rfn;
      rfn = 0;
      n_stall = 0;
      n_wb = 0;
      o_done = 0;
      o_wb_line = '0;
      o_wb_addr = '0;
      o_rf_addr = '0;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (!bus.cpu_stall_o) begin
            o_done = 1;
            break;
         end
         n_stall++;
         if (bus.mem_enable_o && bus.mem_write_o) begin
            n_wb++;
            o_wb_line = bus.mem_data_o;
            o_wb_addr = bus.mem_addr_o;
            bus.mem_ack_i = (n_wb == wb_lat);
         end else if (bus.mem_enable_o) begin
            rfn++;
            o_rf_addr = bus.mem_addr_o;
            if (rfn == rf_lat) begin
               bus.mem_ack_i  = 1'b1;
               bus.mem_data_i = line;
            end
         end
         @(posedge clk);
         #1;
         bus.mem_ack_i = 1'b0;
      end
   endtask

   initial begin
      req(1'b0, 1'b0, 32'h0, 32'h0);
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      line_a = mkline(32'hA000_0000);
      line_a[63:32] = 32'hDEAD_BEEF;

      repeat (2) @(posedge clk);
      #2;
      chk1("rst_stall", bus.cpu_stall_o, 1'b0);
      chk1("rst_men", bus.mem_enable_o, 1'b0);
      chk1("rst_mwr", bus.mem_write_o, 1'b0);
      chk32("rst_maddr", bus.mem_addr_o, 32'h0);
      chk1("rst_mdata", |bus.mem_data_o, 1'b0);
      chk32("rst_cdata", bus.cpu_data_o, 32'h0);
      req(1'b1, 1'b0, 32'h44, 32'h0);
      #1;
      chk1("rst_stall_req", bus.cpu_stall_o, 1'b0);
      step();
      rst = 1'b0;

      // Cold read miss, ack in the 10th refill cycle.
      serve(0, 10, line_a, stalls, wbn, wb_line, wb_addr, rf_addr, done);
      chk1("m1_done", done, 1'b1);
      chk32("m1_stalls", stalls, 12);
      chk32("m1_wb", wbn, 0);
      chk32("m1_rfaddr", rf_addr, 32'h40);
      chk32("m1_data", bus.cpu_data_o, 32'hDEAD_BEEF);

      step();
      req(1'b1, 1'b0, 32'h48, 32'h0);
      #1;
      chk1("h1_stall", bus.cpu_stall_o, 1'b0);
      chk32("h1_data", bus.cpu_data_o, 32'hA000_0002);
      chk1("h1_men", bus.mem_enable_o, 1'b0);

      // Store hit, then conflicting load forces a write-back.
      step();
      req(1'b0, 1'b1, 32'h40, 32'h1234_5678);
      #1;
      chk1("st_stall", bus.cpu_stall_o, 1'b0);
      step();
      req(1'b1, 1'b0, 32'h2000_0040, 32'h0);
      serve(3, 2, mkline(32'hB000_0000), stalls, wbn, wb_line,
            wb_addr, rf_addr, done);
      chk1("wb_done", done, 1'b1);
      chk32("wb_stalls", stalls, 7);
      chk32("wb_cycles", wbn, 3);
      chk32("wb_addr", wb_addr, 32'h40);
      chk32("wb_w0", wb_line[31:0], 32'h1234_5678);
      chk32("wb_w1", wb_line[63:32], 32'hDEAD_BEEF);
      chk32("wb_rfaddr", rf_addr, 32'h2000_0040);
      chk32("wb_data", bus.cpu_data_o, 32'hB000_0000);

      // Write miss allocates, then the store lands as a write hit.
      step();
      req(1'b0, 1'b1, 32'h80, 32'hA5A5_A5A5);
      serve(0, 1, mkline(32'hC000_0000), stalls, wbn, wb_line,
            wb_addr, rf_addr, done);
      chk1("wm_done", done, 1'b1);
      chk32("wm_stalls", stalls, 3);
      chk32("wm_wb", wbn, 0);
      chk32("wm_rfaddr", rf_addr, 32'h80);
      chk32("wm_old", bus.cpu_data_o, 32'hC000_0000);
      step();
      req(1'b1, 1'b0, 32'h80, 32'h0);
      #1;
      chk1("wm_rd_stall", bus.cpu_stall_o, 1'b0);
      chk32("wm_rd_data", bus.cpu_data_o, 32'hA5A5_A5A5);
      step();
      req(1'b1, 1'b0, 32'h2000_0084, 32'h0);
      serve(1, 1, mkline(32'hD000_0000), stalls, wbn, wb_line,
            wb_addr, rf_addr, done);
      chk32("dirty4_stalls", stalls, 4);
      chk32("dirty4_wb", wbn, 1);
      chk32("dirty4_addr", wb_addr, 32'h80);
      chk32("dirty4_w0", wb_line[31:0], 32'hA5A5_A5A5);
      chk32("dirty4_w1", wb_line[63:32], 32'hC000_0001);
      chk32("dirty4_data", bus.cpu_data_o, 32'hD000_0001);

      // Stray ack in idle, then a dual read/write request.
      step();
      req(1'b0, 1'b0, 32'h2000_0040, 32'h0);
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = '1;
      #1;
      chk1("sa_men", bus.mem_enable_o, 1'b0);
      step();
      bus.mem_ack_i = 1'b0;
      req(1'b1, 1'b0, 32'h2000_0040, 32'h0);
      #1;
      chk1("sa_stall", bus.cpu_stall_o, 1'b0);
      chk1("sa_men2", bus.mem_enable_o, 1'b0);
      chk32("sa_data", bus.cpu_data_o, 32'hB000_0000);
      step();
      req(1'b1, 1'b1, 32'h2000_0048, 32'hCAFE_F00D);
      #1;
      chk1("dual_stall", bus.cpu_stall_o, 1'b0);
      chk32("dual_old", bus.cpu_data_o, 32'hB000_0002);
      step();
      req(1'b1, 1'b0, 32'h2000_0048, 32'h0);
      #1;
      chk32("dual_new", bus.cpu_data_o, 32'hCAFE_F00D);

      // Reset in the middle of a refill.
      step();
      req(1'b1, 1'b0, 32'h100, 32'h0);
      #1;
      chk1("rr_stall", bus.cpu_stall_o, 1'b1);
      step();
      #1;
      chk1("rr_men", bus.mem_enable_o, 1'b1);
      chk32("rr_maddr", bus.mem_addr_o, 32'h100);
      #2;
      rst = 1'b1;
      #1;
      chk1("rr_men_rst", bus.mem_enable_o, 1'b0);
      chk1("rr_stall_rst", bus.cpu_stall_o, 1'b0);
      chk32("rr_maddr_rst", bus.mem_addr_o, 32'h0);
      step();
      rst = 1'b0;
      #1;
      chk1("rr_remiss", bus.cpu_stall_o, 1'b1);
      serve(0, 1, mkline(32'hE000_0000), stalls, wbn, wb_line,
            wb_addr, rf_addr, done);
      chk1("rr_done", done, 1'b1);
      chk32("rr_stalls", stalls, 3);
      chk32("rr_rfaddr", rf_addr, 32'h100);
      chk32("rr_data", bus.cpu_data_o, 32'hE000_0000);

      step();
      req(1'b0, 1'b0, 32'h0, 32'h0);
      step();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage of the pipelined CPU.
- Sits between the EX_MEM pipeline register and the off-chip data memory.
- Returns load data toward MEM_WB.
- Drives cpu_stall_o to freeze every pipeline register, including MEM_WB, while a miss is serviced.

Parameters:
- LINES, 16, number of cache lines; the index width is log2(LINES).
- LINE_BITS, 256, line size in bits (32 bytes, 8 words).
- TAG_BITS, 23, tag width; must equal 32 - 5 - log2(LINES).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cpu_addr_i  in  32  byte address. [4:2] word select, [8:5] index, [31:9] tag.
- cpu_data_i  in  32  store data.
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request.
- cpu_data_o  out  32  load data; valid when a read request is present and cpu_stall_o=0.
- cpu_stall_o  out  1  pipeline freeze.
- mem_addr_o  out  32  line-aligned memory address, with [4:0]=0.
- mem_data_o  out  256  write-back line data.
- mem_enable_o  out  1  memory transaction active.
- mem_write_o  out  1  1=write-back, 0=refill.
- mem_data_i  in  256  refill line data; sampled when mem_ack_i=1.
- mem_ack_i  in  1  memory completion, one cycle wide.

Behaviour:
- Storage per line: valid, dirty, tag, LINE_BITS of data.
- Reset clears all valid and dirty bits and forces state=IDLE. Data and tag arrays are not cleared.
- Output reset values: cpu_stall_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0.
- req = cpu_MemRead_i | cpu_MemWrite_i. If both are high, the request is treated as a store.
- hit = valid[idx] & (tag[idx]==addr tag). Hit detection is combinational.
- cpu_stall_o = req & (state!=IDLE | !hit). It is combinational.
- cpu_data_o is the selected 32-bit word of line[idx] when req & hit, otherwise 0.
- Read hit: zero-stall; data is available in the same cycle.
- Write hit: the selected word is updated and dirty[idx] set at the next rising edge. Other words are unchanged and there is no stall.
- The CPU must hold addr, data and request stable while cpu_stall_o=1. The controller does not latch them.
- FSM states: IDLE, WRITEBACK, REFILL, DONE.
- Memory outputs are decoded from the state, so reset deasserts them immediately.
- IDLE:
  - req & !hit & valid & dirty goes to WRITEBACK.
  - req & !hit otherwise goes to REFILL.
  - Otherwise stay in IDLE.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o = {victim tag, idx, 5'b0}; mem_data_o = victim line.
  - Stay until mem_ack_i=1, then go to REFILL.
- REFILL:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, idx, 5'b0}.
  - On mem_ack_i=1: line[idx]=mem_data_i, tag updated, valid=1, dirty=0, go to DONE.
- DONE: mem_enable_o=0, stall held; go to IDLE. In IDLE the request now hits, and a store is performed as a write hit.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- An ack in the same cycle the state is entered is accepted, giving a minimum of one cycle per transaction.
- Stall timing:
  - Clean miss: stall cycles = 1 (IDLE detect) + N (REFILL cycles up to and including the ack cycle) + 1 (DONE).
  - Dirty miss: additionally + M WRITEBACK cycles.
- Reset mid-miss: the FSM returns to IDLE and the transaction is abandoned. The line being refilled is not validated. Memory must tolerate an abandoned request.
- Index wrap: addresses differing only in [31:9] conflict on the same line. There is no associativity.

Test Plan:
- Read miss on a cold cache, addr 0x0000_0040, memory acks in the 10th REFILL cycle with word1=0xDEADBEEF -> mem_enable_o=1, mem_write_o=0, mem_addr_o=0x40. Stall is high 12 cycles and low on the 13th. cpu_data_o=0xDEADBEEF with the addr held at 0x44.
- Read hit immediately after, same line, addr 0x0000_0048 -> cpu_stall_o=0 in the same cycle, cpu_data_o = refilled word2. No memory activity.
- Store 0x12345678 to 0x40 (hit), then load 0x2000_0040 (same index, different tag):
  - Store takes no stall.
  - Load enters WRITEBACK with mem_addr_o=0x40, mem_write_o=1, and mem_data_o word0=0x12345678.
  - After the ack it enters REFILL with mem_addr_o=0x2000_0040.
- Write miss to a clean/invalid line, addr 0x80, data 0xA5A5A5A5 -> refill from 0x80, then the store completes in IDLE. dirty[4]=1, and a later read of 0x80 returns 0xA5A5A5A5 with no stall.
- Assert rst_i during REFILL -> mem_enable_o and cpu_stall_o drop asynchronously. The line stays invalid, and a retry of the same load misses again.
- Ack pulses in IDLE, and both MemRead and MemWrite high on a hit -> the stray ack causes no state change. The dual request is performed as a store.
